// File: rtl/mul_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_ctrl_pkg
//  Description : Shared constants for the sequential multiplier controller:
//                FSM state encoding, default multiplier latency and the
//                width of the latency down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_ctrl_pkg;

    // Width of the latency counter; wide enough for MUL_LATENCY-1 up to 14
    localparam int unsigned c_CNT_W           = 4;

    // Cycles the multiplier inputs are held before the product is sampled
    localparam int unsigned c_MUL_LATENCY_DEF = 4;

    // FSM state encoding
    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_WAIT  = 2'd1;
    localparam logic [1:0]  c_ST_WB_LO = 2'd2;
    localparam logic [1:0]  c_ST_WB_HI = 2'd3;

endpackage : mul_ctrl_pkg
`default_nettype wire

// File: rtl/mul_lat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_lat_counter
//  Description : Loadable down-counter with a zero flag. Counts the cycles
//                the multiplier inputs must stay stable before capture.
//                Decrementing stops at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_lat_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority over decrement; saturate at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : mul_lat_counter
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl
//  Description : Multi-cycle sequencer around the external combinational
//                8x8 multiplier. Latches operands/destination on START,
//                holds them for MUL_LATENCY cycles, captures the 16-bit
//                product and issues a register-file write-back.
//                Optional macro MUL_HI_WB_EN adds a second write-back of the
//                product's upper byte to DEST+1 (wrapping).
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = c_MUL_LATENCY_DEF,  // legal 1..15
    parameter int unsigned REG_ADDR_W  = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [7:0]            OP1,
    input  logic [7:0]            OP2,
    input  logic [REG_ADDR_W-1:0] DEST,
    output logic [7:0]            MUL_A,
    output logic [7:0]            MUL_B,
    input  logic [15:0]           MUL_PRODUCT,
    output logic                  BUSY,
    output logic [7:0]            WRITEDATA,
    output logic [REG_ADDR_W-1:0] WRITEREG,
    output logic                  WRITEENABLE,
    output logic                  OVF,
    output logic                  DONE
);

    // Without the high-byte write-back only the low byte needs storing;
    // the upper byte is summarised by OVF at capture time.
`ifdef MUL_HI_WB_EN
    localparam int unsigned c_RES_W = 16;
`else
    localparam int unsigned c_RES_W = 8;
`endif

    localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(MUL_LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic [7:0]            a_q, a_d;
    logic [7:0]            b_q, b_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [c_RES_W-1:0]    result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q;
    logic                  we_q, we_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic                  done_q, done_d;

    logic                  w_accept;
    logic                  w_cnt_zero;
    logic                  w_capture;

    assign w_accept  = (state_q == c_ST_IDLE) && START;
    assign w_capture = (state_q == c_ST_WAIT) && w_cnt_zero;

    mul_lat_counter #(
        .CNT_W      (c_CNT_W)
    ) u_lat_cnt (
        .clk        (CLK),
        .rst        (RESET),
        .load_i     (w_accept),
        .load_val_i (c_LOAD),
        .dec_i      (state_q == c_ST_WAIT),
        .zero_o     (w_cnt_zero)
    );

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (START)      state_d = c_ST_WAIT;
            c_ST_WAIT:  if (w_cnt_zero) state_d = c_ST_WB_LO;
`ifdef MUL_HI_WB_EN
            c_ST_WB_LO: state_d = c_ST_WB_HI;
            c_ST_WB_HI: state_d = c_ST_IDLE;
`else
            c_ST_WB_LO: state_d = c_ST_IDLE;
`endif
            default:    state_d = c_ST_IDLE;
        endcase
    end

    // Operand/destination latch on accept, product capture at end of WAIT
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        dest_d   = dest_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        if (w_accept) begin
            a_d    = OP1;
            b_d    = OP2;
            dest_d = DEST;
        end
        if (w_capture) begin
            result_d = MUL_PRODUCT[c_RES_W-1:0];
            ovf_d    = |MUL_PRODUCT[15:8];
        end
    end

    // Write-back outputs, decoded from the state being entered so they
    // appear registered during the write-back cycle itself
    always_comb begin
        we_d    = 1'b0;
        wdata_d = 8'h00;
        wreg_d  = '0;
        done_d  = 1'b0;
        case (state_d)
            c_ST_WB_LO: begin
                we_d    = 1'b1;
                wdata_d = result_d[7:0];
                wreg_d  = dest_q;
`ifndef MUL_HI_WB_EN
                done_d  = 1'b1;
`endif
            end
`ifdef MUL_HI_WB_EN
            c_ST_WB_HI: begin
                we_d    = 1'b1;
                wdata_d = result_q[15:8];
                wreg_d  = dest_q + REG_ADDR_W'(1);
                done_d  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            dest_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= 8'h00;
            wreg_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            dest_q   <= dest_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= (state_d != c_ST_IDLE);
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wreg_q   <= wreg_d;
            done_q   <= done_d;
        end
    end

    assign MUL_A       = a_q;
    assign MUL_B       = b_q;
    assign BUSY        = busy_q;
    assign WRITEDATA   = wdata_q;
    assign WRITEREG    = wreg_q;
    assign WRITEENABLE = we_q;
    assign OVF         = ovf_q;
    assign DONE        = done_q;

endmodule : mul_seq_ctrl
`default_nettype wire

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer wrapped around the combinational 8x8 array multiplier in the ALU datapath.
- Upstream side: latches the operands and destination register on START, then holds the multiplier inputs stable for MUL_LATENCY cycles so the long ripple path settles.
- Downstream side: captures the 16-bit product and drives a register-file write-back, with BUSY stalling the CPU meanwhile.

Parameters:
- MUL_LATENCY, 4, number of cycles the multiplier inputs are held before capture; legal range 1..15.
- REG_ADDR_W, 3, register-file address width.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request a multiply; sampled only in IDLE.
- OP1  in  8  multiplicand from register file.
- OP2  in  8  multiplier from register file.
- DEST  in  REG_ADDR_W  destination register address.
- MUL_A  out  8  latched OP1, to multiplier DATA1.
- MUL_B  out  8  latched OP2, to multiplier DATA2.
- MUL_PRODUCT  in  16  product returned from multiplier.
- BUSY  out  1  high whenever state is not IDLE; CPU stalls PC on it.
- WRITEDATA  out  8  write-back data to register file.
- WRITEREG  out  REG_ADDR_W  write-back address.
- WRITEENABLE  out  1  register-file write strobe.
- OVF  out  1  high when the captured product has a nonzero upper byte, i.e. product[15:8] != 0.
- DONE  out  1  one-cycle pulse during the final write-back cycle.

Behaviour:
- Reset: one clock, CLK; RESET is asynchronous and active-high.
  - On RESET, state goes to IDLE.
  - All registered outputs go to 0: MUL_A, MUL_B, WRITEDATA, WRITEREG, WRITEENABLE, OVF, DONE.
  - The internal result register and the counter are cleared.
- States: IDLE, WAIT, WB_LO, plus WB_HI when the optional feature is enabled. Encoding lives in the package.
- IDLE:
  - On an edge with START=1, latch OP1/OP2 into MUL_A/MUL_B, latch DEST, load cnt=MUL_LATENCY-1, go to WAIT.
  - START=0 keeps the block in IDLE.
- WAIT:
  - MUL_A/MUL_B are held constant.
  - On each edge: if cnt==0, capture MUL_PRODUCT into the result register, update OVF, go to WB_LO; otherwise decrement cnt.
  - Capture therefore happens exactly MUL_LATENCY edges after the START-accept edge.
- WB_LO:
  - WRITEENABLE=1, WRITEDATA=result[7:0], WRITEREG=latched DEST.
  - DONE=1 when the optional feature is disabled.
  - Next edge goes to IDLE, or to WB_HI when the feature is enabled.
- Latency: the register-file write commits at edge MUL_LATENCY+1 after the accept edge.
- BUSY:
  - Registered from state; it is first high in the cycle after the accept edge.
  - The CPU holds START and its operands until BUSY rises.
  - START has no effect while BUSY=1.
- WRITEENABLE, WRITEDATA, WRITEREG and DONE are 0 in every cycle that is not a write-back cycle.
- OVF is held from capture until the next capture or reset.
- Back-to-back operation: START asserted during WB_LO is ignored. The next START is accepted on the first edge in IDLE.
- Reset mid-operation (any state): return to IDLE immediately with no write-back issued. The partially computed result is discarded.
- Arithmetic: unsigned multiply only. No sign handling in this block.

Optional Feature:
- Macro: MUL_HI_WB_EN.
- Defined:
  - WB_LO does not pulse DONE and moves to WB_HI.
  - WB_HI drives WRITEENABLE=1, WRITEDATA=result[15:8], WRITEREG=DEST+1 modulo 2^REG_ADDR_W (so 7 wraps to 0), DONE=1, then goes to IDLE.
  - Total latency becomes MUL_LATENCY+2 edges.
- Undefined:
  - The WB_HI state is not compiled.
  - The upper byte is observable only through OVF.

Decomposition:
- Package mul_ctrl_pkg holds:
  - state encoding constants (IDLE=0, WAIT=1, WB_LO=2, WB_HI=3);
  - the default MUL_LATENCY;
  - the counter width constant (4).
- Natural sub-module mul_lat_counter: loadable down-counter with a zero flag, used by WAIT.
- The multiplier itself is instantiated outside this block, at the ALU level.

Test Plan:
- MUL_LATENCY=4, OP1=3, OP2=5, DEST=2, START pulse: BUSY rises the next cycle; WRITEENABLE=1 with WRITEDATA=0x0F, WRITEREG=2 in the cycle after edge 4; OVF=0; DONE pulses once; BUSY falls after edge 5.
- OP1=0xFF, OP2=0xFF, DEST=6: product 0xFE01; WRITEDATA=0x01, OVF=1. With MUL_HI_WB_EN, the next cycle shows WRITEDATA=0xFE, WRITEREG=7, DONE=1.
- DEST=7 with MUL_HI_WB_EN, OP1=0x80, OP2=0x04: low write 0x00 to reg 7, then high write 0x02 to reg 0 (wrap-around).
- Start a multiply with OP1=2, OP2=2, then pulse START with OP1=9, OP2=9 during WAIT and again during WB_LO: both pulses ignored; only result 0x04 is written; a START on the first IDLE cycle is accepted.
- Assert RESET for one cycle mid-WAIT (cnt=1): all outputs 0 immediately, state IDLE, no WRITEENABLE pulse follows; a subsequent 7*6 operation writes 0x2A normally.
- MUL_LATENCY=1, OP1=10, OP2=10: capture on the edge after accept; WRITEDATA=0x64 in the next cycle; OVF=0.
